// File: rtl/ivl_uvm_handshake_responder.sv
// Ack-driving end of a four-phase req/ack handshake: raises ack a clamped number of
// clocks after accepting req, holds it until req drops, and flags early req withdrawal.
module ivl_uvm_handshake_responder #(
  parameter int MIN_ACK_CYCLE = 1,
  parameter int MAX_ACK_CYCLE = 3,
  parameter int DLY_W         = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req,
  input  logic [DLY_W-1:0] delay_cfg,
  output logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_req_drop
);

  localparam logic [DLY_W-1:0] MIN_D = DLY_W'(MIN_ACK_CYCLE);
  localparam logic [DLY_W-1:0] MAX_D = DLY_W'(MAX_ACK_CYCLE);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]       state;
  logic [DLY_W-1:0] cnt;
  logic [DLY_W-1:0] eff_delay;

  always_comb begin
    eff_delay = delay_cfg;
    if (delay_cfg < MIN_D)
      eff_delay = MIN_D;
    else if (delay_cfg > MAX_D)
      eff_delay = MAX_D;
  end

  // cnt holds the remaining WAIT edges; ack rises on the edge where it has reached zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      ack          <= 1'b0;
      busy         <= 1'b0;
      cnt          <= '0;
      txn_count    <= '0;
      err_req_drop <= 1'b0;
    end else begin
      err_req_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (req && enable) begin
            cnt   <= eff_delay - DLY_W'(1);
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (!req) begin
            err_req_drop <= 1'b1;
            state        <= IDLE;
            busy         <= 1'b0;
          end else if (cnt == '0) begin
            ack   <= 1'b1;
            state <= ACK;
          end else begin
            cnt <= cnt - DLY_W'(1);
          end
        end
        ACK: begin
          if (!req) begin
            ack       <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ivl_uvm_handshake_responder.sv
// Self-checking bench for ivl_uvm_handshake_responder: scripted scenarios plus a
// randomized run compared against a transaction-level reference model.
module tb_ivl_uvm_handshake_responder;

  localparam int MIN_ACK = 1;
  localparam int MAX_ACK = 3;
  localparam int DLY_W   = 4;
  localparam int CNT_W   = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic             req = 1'b0;
  logic [DLY_W-1:0] delay_cfg = '0;
  logic             ack;
  logic             busy;
  logic [CNT_W-1:0] txn_count;
  logic             err_req_drop;

  int checks = 0;
  int errors = 0;

  ivl_uvm_handshake_responder #(
    .MIN_ACK_CYCLE(MIN_ACK),
    .MAX_ACK_CYCLE(MAX_ACK),
    .DLY_W(DLY_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .req(req),
    .delay_cfg(delay_cfg),
    .ack(ack),
    .busy(busy),
    .txn_count(txn_count),
    .err_req_drop(err_req_drop)
  );

  always #5 clock = ~clock;

  // Reference model: a transaction is "active" from acceptance, "acked" once the
  // number of edges since acceptance equals the clamped delay.
  bit m_active = 0;
  bit m_acked  = 0;
  bit m_err    = 0;
  int m_elapsed = 0;
  int m_d = 0;
  int m_count = 0;
  int req_low_run = 0;

  always @(posedge clock) begin
    req_low_run = req ? 0 : req_low_run + 1;
    if (reset) begin
      m_active = 0; m_acked = 0; m_err = 0; m_elapsed = 0; m_count = 0;
    end else begin
      m_err = 0;
      if (!m_active) begin
        if (req && enable) begin
          m_active  = 1;
          m_acked   = 0;
          m_elapsed = 0;
          m_d = (int'(delay_cfg) < MIN_ACK) ? MIN_ACK :
                (int'(delay_cfg) > MAX_ACK) ? MAX_ACK : int'(delay_cfg);
        end
      end else if (!m_acked) begin
        m_elapsed++;
        if (!req) begin
          m_err = 1;
          m_active = 0;
        end else if (m_elapsed == m_d) begin
          m_acked = 1;
        end
      end else if (!req) begin
        m_active = 0;
        m_acked  = 0;
        m_count  = (m_count + 1) % (1 << CNT_W);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b1; enable = 1'b1; delay_cfg = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || txn_count !== 2'd0 || err_req_drop !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hold cycle %0d: ack=%b busy=%b txn=%0d err=%b, required 0 0 0 0",
                 i, ack, busy, txn_count, err_req_drop);
      end
    end
    reset = 1'b0; req = 1'b0;
    tick();
  endtask

  task automatic test_basic_delay();
    do_reset();
    delay_cfg = 4'd2; req = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || ack !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_accept: busy=%b ack=%b, required 1 0", busy, ack);
    end
    tick();
    checks++;
    if (ack !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_n1: ack=%b, required 0", ack);
    end
    tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_n2: ack=%b, required 1", ack);
    end
    tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_hold: ack=%b, required 1", ack);
    end
    req = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || txn_count !== 2'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_release: ack=%b txn=%0d busy=%b, required 0 1 0", ack, txn_count, busy);
    end
  endtask

  task automatic test_clamp();
    logic [DLY_W-1:0] cfgs [2];
    int expected [2];
    int edges;
    cfgs[0] = 4'd0; expected[0] = MIN_ACK + 1;
    cfgs[1] = 4'd9; expected[1] = MAX_ACK + 1;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      delay_cfg = cfgs[t]; req = 1'b1;
      edges = 0;
      while (edges < 10) begin
        tick();
        edges++;
        if (edges == 1) delay_cfg = 4'd15 - cfgs[t];
        if (ack === 1'b1) break;
      end
      checks++;
      if (edges != expected[t]) begin
        errors++;
        $display("[TB] FAIL clamp cfg=%0d: ack after %0d edges, required %0d", cfgs[t], edges, expected[t]);
      end
      req = 1'b0;
      tick();
      checks++;
      if (ack !== 1'b0 || txn_count !== 2'd1) begin
        errors++;
        $display("[TB] FAIL clamp_release cfg=%0d: ack=%b txn=%0d, required 0 1", cfgs[t], ack, txn_count);
      end
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    delay_cfg = 4'd3; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    checks++;
    if (err_req_drop !== 1'b1 || ack !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL req_drop_pulse: err=%b ack=%b busy=%b, required 1 0 0", err_req_drop, ack, busy);
    end
    tick();
    checks++;
    if (err_req_drop !== 1'b0 || ack !== 1'b0 || txn_count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL req_drop_after: err=%b ack=%b txn=%0d, required 0 0 0", err_req_drop, ack, txn_count);
    end
  endtask

  task automatic test_enable();
    int edges;
    do_reset();
    enable = 1'b0; req = 1'b1; delay_cfg = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== 1'b0) begin
        errors++;
        $display("[TB] FAIL enable_low cycle %0d: busy=%b ack=%b, required 0 0", i, busy, ack);
      end
    end
    enable = 1'b1;
    edges = 0;
    while (edges < 10) begin
      tick();
      edges++;
      if (ack === 1'b1) break;
    end
    checks++;
    if (edges != 3) begin
      errors++; $display("[TB] FAIL enable_resume: ack after %0d edges, required 3", edges);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("[TB] FAIL enable_off_in_ack: ack=%b, required 1", ack);
    end
    req = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || txn_count !== 2'd1) begin
      errors++; $display("[TB] FAIL enable_off_complete: ack=%b txn=%0d, required 0 1", ack, txn_count);
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    int seq [5];
    seq = '{1, 2, 3, 0, 1};
    do_reset();
    delay_cfg = 4'd1; req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || ack !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_accept %0d: busy=%b ack=%b, required 1 0", i, busy, ack);
      end
      tick();
      checks++;
      if (ack !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_ack %0d: ack=%b, required 1", i, ack);
      end
      req = 1'b0;
      tick();
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || txn_count !== CNT_W'(seq[i])) begin
        errors++;
        $display("[TB] FAIL b2b_done %0d: ack=%b busy=%b txn=%0d, required 0 0 %0d", i, ack, busy, txn_count, seq[i]);
      end
      req = 1'b1;
    end
    tick(); tick();
    checks++;
    if (ack !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_mid_ack_pre: ack=%b, required 1", ack);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b0 || txn_count !== 2'd0 || busy !== 1'b0 || err_req_drop !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_ack: ack=%b txn=%0d busy=%b err=%b, required 0 0 0 0", ack, txn_count, busy, err_req_drop);
    end
    reset = 1'b0; req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 3) == 0) req = ~req;
      enable = ($urandom_range(0, 3) != 0);
      delay_cfg = DLY_W'($urandom_range(0, 15));
      tick();
      checks++;
      if (ack !== m_acked || busy !== m_active || err_req_drop !== m_err ||
          txn_count !== CNT_W'(m_count)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: ack=%b busy=%b err=%b txn=%0d, required %b %b %b %0d",
                 i, ack, busy, err_req_drop, txn_count, m_acked, m_active, m_err, m_count);
      end
      checks++;
      if (ack === 1'b1 && req_low_run >= 2) begin
        errors++;
        $display("[TB] FAIL ack_after_req_low cycle %0d: ack=%b with req low %0d edges, required 0", i, ack, req_low_run);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_delay();
    test_clamp();
    test_req_drop();
    test_enable();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
